// File: rtl/tpu_host_seq.sv
// -----------------------------------------------------------------------------
// tpu_host_seq
//   Host-side initiator for the TPU pin protocol. Accepts one 2x2 A and one 2x2
//   B operand (DATA_W-bit elements), writes the 8 elements to the TPU, waits for
//   done, reads back C0..C3 through output_en/output_sel and returns packed C
//   with a one-cycle res_valid pulse. Every output is a flop.
//
//   Optional build macro: HOST_TIMEOUT_EN
//     defined   : WAIT_DONE aborts after TIMEOUT_CYC cycles without done,
//                 reporting err_timeout=1 with c_mat=0 and no read phase.
//     undefined : WAIT_DONE waits indefinitely; err_timeout stays 0.
//
//   Ports
//     clk, rst_n         clock, synchronous active-low reset
//     start              request, sampled only in IDLE
//     a_mat, b_mat       operands, elem k at [k*DATA_W +: DATA_W]
//     busy               high from the cycle after accept through RESP
//     res_valid          one-cycle pulse; c_mat/err_timeout valid
//     c_mat              result, elem k at [k*DATA_W +: DATA_W]
//     err_timeout        WAIT_DONE expired (timeout build only)
//     tpu_load_*         element write pins toward the TPU
//     tpu_output_en/sel  result read pins toward the TPU
//     tpu_out_data       result data from the TPU
//     tpu_done           TPU completion level
// -----------------------------------------------------------------------------
module tpu_host_seq #(
    parameter int DATA_W      = 8,
    parameter int RD_LAT      = 1,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic [4*DATA_W-1:0] a_mat,
    input  logic [4*DATA_W-1:0] b_mat,
    output logic                busy,
    output logic                res_valid,
    output logic [4*DATA_W-1:0] c_mat,
    output logic                err_timeout,
    output logic                tpu_load_en,
    output logic                tpu_load_sel_ab,
    output logic [1:0]          tpu_load_index,
    output logic [DATA_W-1:0]   tpu_in_data,
    output logic                tpu_output_en,
    output logic [1:0]          tpu_output_sel,
    input  logic [DATA_W-1:0]   tpu_out_data,
    input  logic                tpu_done
);

    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_WAIT, S_READ, S_RESP} state_t;
    typedef logic [3:0][DATA_W-1:0] mat_t;

    // One counter walks the load writes, the read elements and, in the
    // timeout build, the WAIT_DONE cycles; sized for whichever is larger.
    localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);
    localparam int CNT_W = (TMO_W > 4) ? TMO_W : 4;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [1:0]         sub_q, sub_d;      // cycle within one read window
    mat_t               a_q, a_d, b_q, b_d, c_q, c_d;
    logic               err_q, err_d;
    logic               busy_q, busy_d, rv_q, rv_d;
    logic               ld_en_q, ld_en_d, ld_ab_q, ld_ab_d;
    logic [1:0]         ld_idx_q, ld_idx_d;
    logic [DATA_W-1:0]  ld_data_q, ld_data_d;
    logic               oe_q, oe_d;
    logic [1:0]         osel_q, osel_d;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        sub_d   = sub_q;
        a_d     = a_q;
        b_d     = b_q;
        c_d     = c_q;
        err_d   = err_q;

        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    a_d     = a_mat;
                    b_d     = b_mat;
                    c_d     = '0;
                    err_d   = 1'b0;
                    cnt_d   = '0;
                    state_d = S_LOAD;
                end
            end
            S_LOAD: begin
                if (cnt_q == CNT_W'(7)) begin
                    cnt_d   = '0;
                    state_d = S_WAIT;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_WAIT: begin
                // done wins over a same-cycle expiry
                if (tpu_done) begin
                    cnt_d   = '0;
                    sub_d   = '0;
                    state_d = S_READ;
                end
`ifdef HOST_TIMEOUT_EN
                else if (cnt_q == CNT_W'(TIMEOUT_CYC - 1)) begin
                    err_d   = 1'b1;
                    c_d     = '0;
                    state_d = S_RESP;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
`endif
            end
            S_READ: begin
                if (sub_q == 2'(RD_LAT)) begin
                    // last edge of this element's window: data is valid now
                    c_d[cnt_q[1:0]] = tpu_out_data;
                    sub_d = '0;
                    if (cnt_q[1:0] == 2'd3) state_d = S_RESP;
                    else                    cnt_d   = cnt_q + 1'b1;
                end else begin
                    sub_d = sub_q + 1'b1;
                end
            end
            S_RESP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        // Pin values are derived from the next state so they appear
        // registered in the same cycle the state is entered.
        busy_d    = (state_d != S_IDLE);
        rv_d      = (state_d == S_RESP);
        ld_en_d   = (state_d == S_LOAD);
        ld_ab_d   = ld_en_d & cnt_d[2];
        ld_idx_d  = ld_en_d ? cnt_d[1:0] : 2'd0;
        ld_data_d = '0;
        if (ld_en_d) ld_data_d = cnt_d[2] ? b_d[cnt_d[1:0]] : a_d[cnt_d[1:0]];
        oe_d      = (state_d == S_READ);
        osel_d    = oe_d ? cnt_d[1:0] : 2'd0;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            sub_q     <= '0;
            a_q       <= '0;
            b_q       <= '0;
            c_q       <= '0;
            err_q     <= 1'b0;
            busy_q    <= 1'b0;
            rv_q      <= 1'b0;
            ld_en_q   <= 1'b0;
            ld_ab_q   <= 1'b0;
            ld_idx_q  <= '0;
            ld_data_q <= '0;
            oe_q      <= 1'b0;
            osel_q    <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            sub_q     <= sub_d;
            a_q       <= a_d;
            b_q       <= b_d;
            c_q       <= c_d;
            err_q     <= err_d;
            busy_q    <= busy_d;
            rv_q      <= rv_d;
            ld_en_q   <= ld_en_d;
            ld_ab_q   <= ld_ab_d;
            ld_idx_q  <= ld_idx_d;
            ld_data_q <= ld_data_d;
            oe_q      <= oe_d;
            osel_q    <= osel_d;
        end
    end

    assign busy            = busy_q;
    assign res_valid       = rv_q;
    assign c_mat           = c_q;
    assign err_timeout     = err_q;
    assign tpu_load_en     = ld_en_q;
    assign tpu_load_sel_ab = ld_ab_q;
    assign tpu_load_index  = ld_idx_q;
    assign tpu_in_data     = ld_data_q;
    assign tpu_output_en   = oe_q;
    assign tpu_output_sel  = osel_q;

endmodule
